// File: rtl/icache_mshr_ctrl_pkg.sv
// Shared types and bus encodings for the I-cache miss/prefetch controller.
package icache_mshr_ctrl_pkg;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  typedef enum logic [1:0] {
    MSHR_IDLE    = 2'd0,
    MSHR_PENDING = 2'd1,
    MSHR_WAIT    = 2'd2
  } MSHR_STATE_T;

  typedef struct packed {
    MSHR_STATE_T state;
    logic [60:0] line_addr;
    logic [3:0]  mem_tag;
    logic        is_pf;
  } ICACHE_MSHR_T;

endpackage

// File: rtl/icache_mshr_ctrl_if.sv
// Tagged memory bus between the I-cache fill controller (master) and main memory (slave).
interface icache_mshr_ctrl_if;

  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

endinterface

// File: rtl/icache_pick_lowest.sv
// Lowest-set-bit selector: one-hot of the lowest requesting bit plus an any-request flag.
module icache_pick_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] onehot,
  output logic             valid
);

  assign onehot = req & (~req + WIDTH'(1));
  assign valid  = |req;

endmodule

// File: rtl/icache_mshr_ctrl.sv
// Non-blocking I-cache fill controller tracking NUM_MSHR in-flight line fills by memory tag.
// Next-line prefetch allocation is built only when ICACHE_PREFETCH_EN is defined.
module icache_mshr_ctrl
  import icache_mshr_ctrl_pkg::*;
#(
  parameter  int NUM_MSHR     = 4,
  parameter  int NUM_PREFETCH = 2,
  parameter  int NUM_SETS     = 8,
  localparam int SET_BITS     = $clog2(NUM_SETS),
  localparam int TAG_BITS     = 29 - SET_BITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [63:0]                   fetch_addr,
  input  logic                          fetch_hit,
  input  logic                          flush,
  output logic [NUM_PREFETCH-1:0][63:0] pf_probe_addr,
  input  logic [NUM_PREFETCH-1:0]       pf_probe_hit,
  output logic                          miss_pending,
  icache_mshr_ctrl_if.master            mem,
  output logic                          cache_wr_en,
  output logic [SET_BITS-1:0]           cache_wr_idx,
  output logic [TAG_BITS-1:0]           cache_wr_tag,
  output logic [63:0]                   cache_wr_data
);

  ICACHE_MSHR_T mshr_q [NUM_MSHR];
  ICACHE_MSHR_T mshr_d [NUM_MSHR];

  logic [60:0]         fetch_line;
  logic [NUM_MSHR-1:0] idle_v, pend_dem_v, pend_pf_v, fetch_match_v, cmpl_match_v;
  logic [NUM_MSHR-1:0] dem_issue_oh, pf_issue_oh, issue_oh, accept_oh;
  logic [NUM_MSHR-1:0] free_oh, repl_oh, cmpl_oh, demand_oh, pf_alloc_oh;
  logic                dem_issue_vld, pf_issue_vld, free_vld, repl_vld, cmpl_vld;
  logic                need_demand, issue_vld;
  logic [60:0]         issue_line;
  logic [28:0]         cmpl_line;
  logic [60:0]         pf_alloc_line [NUM_MSHR];

  assign fetch_line = fetch_addr[63:3];

  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      idle_v[i]        = (mshr_q[i].state == MSHR_IDLE);
      pend_dem_v[i]    = (mshr_q[i].state == MSHR_PENDING) && !mshr_q[i].is_pf;
      pend_pf_v[i]     = (mshr_q[i].state == MSHR_PENDING) && mshr_q[i].is_pf;
      fetch_match_v[i] = (mshr_q[i].state != MSHR_IDLE) && (mshr_q[i].line_addr == fetch_line);
      cmpl_match_v[i]  = (mshr_q[i].state == MSHR_WAIT) && (mem.Imem2proc_tag != 4'd0) &&
                         (mshr_q[i].mem_tag == mem.Imem2proc_tag);
    end
  end

  icache_pick_lowest #(.WIDTH(NUM_MSHR)) u_issue_dem (
    .req(pend_dem_v), .onehot(dem_issue_oh), .valid(dem_issue_vld));
  icache_pick_lowest #(.WIDTH(NUM_MSHR)) u_issue_pf (
    .req(pend_pf_v), .onehot(pf_issue_oh), .valid(pf_issue_vld));
  icache_pick_lowest #(.WIDTH(NUM_MSHR)) u_free (
    .req(idle_v), .onehot(free_oh), .valid(free_vld));
  // A prefetch accepted by memory this cycle is already in flight, so it is not a victim.
  icache_pick_lowest #(.WIDTH(NUM_MSHR)) u_repl (
    .req(pend_pf_v & ~accept_oh), .onehot(repl_oh), .valid(repl_vld));
  icache_pick_lowest #(.WIDTH(NUM_MSHR)) u_cmpl (
    .req(cmpl_match_v), .onehot(cmpl_oh), .valid(cmpl_vld));

  assign issue_vld   = dem_issue_vld || pf_issue_vld;
  assign issue_oh    = dem_issue_vld ? dem_issue_oh : pf_issue_oh;
  assign accept_oh   = (mem.Imem2proc_response != 4'd0) ? issue_oh : '0;
  assign need_demand = !reset && !fetch_hit && !(|fetch_match_v);

  always_comb begin
    demand_oh = '0;
    if (need_demand) begin
      if (free_vld)      demand_oh = free_oh;
      else if (repl_vld) demand_oh = repl_oh;
    end
  end

  always_comb begin
    issue_line = '0;
    cmpl_line  = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (issue_oh[i]) issue_line = issue_line | mshr_q[i].line_addr;
      if (cmpl_oh[i])  cmpl_line  = cmpl_line | mshr_q[i].line_addr[28:0];
    end
  end

  assign mem.proc2Imem_command = issue_vld ? BUS_LOAD : BUS_NONE;
  assign mem.proc2Imem_addr    = issue_vld ? {issue_line, 3'b000} : 64'd0;
  assign miss_pending          = !reset && !fetch_hit && ((|fetch_match_v) || (|demand_oh));

`ifdef ICACHE_PREFETCH_EN
  logic [63:0] last_fetch_addr;
  logic        new_fetch;

  always_ff @(posedge clock) begin
    if (reset) last_fetch_addr <= '1;
    else       last_fetch_addr <= fetch_addr;
  end

  assign new_fetch = !reset && (fetch_addr != last_fetch_addr);

  // Candidates take the remaining free entries in k order; with none left the candidate is dropped.
  always_comb begin
    logic [NUM_MSHR-1:0] avail;
    logic [NUM_MSHR-1:0] pick;
    logic [60:0]         cand;
    logic                cand_match;
    avail         = idle_v & ~demand_oh;
    pick          = '0;
    cand          = '0;
    cand_match    = 1'b0;
    pf_alloc_oh   = '0;
    pf_probe_addr = '0;
    for (int i = 0; i < NUM_MSHR; i++) pf_alloc_line[i] = '0;
    for (int k = 0; k < NUM_PREFETCH; k++) begin
      cand             = fetch_line + 61'(k + 1);
      pf_probe_addr[k] = {cand, 3'b000};
      cand_match       = 1'b0;
      for (int i = 0; i < NUM_MSHR; i++) begin
        if ((mshr_q[i].state != MSHR_IDLE) && (mshr_q[i].line_addr == cand)) cand_match = 1'b1;
      end
      pick = avail & (~avail + NUM_MSHR'(1));
      if (new_fetch && !pf_probe_hit[k] && !cand_match) begin
        for (int i = 0; i < NUM_MSHR; i++) begin
          if (pick[i]) begin
            pf_alloc_oh[i]   = 1'b1;
            pf_alloc_line[i] = cand;
          end
        end
        avail = avail & ~pick;
      end
    end
  end
`else
  logic unused_pf;
  assign unused_pf = ^{pf_probe_hit, fetch_addr[2:0]};

  always_comb begin
    pf_alloc_oh   = '0;
    pf_probe_addr = '0;
    for (int i = 0; i < NUM_MSHR; i++) pf_alloc_line[i] = '0;
  end
`endif

  // Allocation wins over everything; an accepted issue reaches WAIT even when flushed.
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      mshr_d[i] = mshr_q[i];
      if (demand_oh[i]) begin
        mshr_d[i].state     = MSHR_PENDING;
        mshr_d[i].line_addr = fetch_line;
        mshr_d[i].mem_tag   = 4'd0;
        mshr_d[i].is_pf     = 1'b0;
      end else if (pf_alloc_oh[i]) begin
        mshr_d[i].state     = MSHR_PENDING;
        mshr_d[i].line_addr = pf_alloc_line[i];
        mshr_d[i].mem_tag   = 4'd0;
        mshr_d[i].is_pf     = 1'b1;
      end else if (accept_oh[i]) begin
        mshr_d[i].state     = MSHR_WAIT;
        mshr_d[i].mem_tag   = mem.Imem2proc_response;
      end else if (cmpl_oh[i]) begin
        mshr_d[i].state     = MSHR_IDLE;
      end else if (flush && pend_pf_v[i]) begin
        mshr_d[i].state     = MSHR_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++)
        mshr_q[i] <= '{state: MSHR_IDLE, line_addr: '0, mem_tag: '0, is_pf: 1'b0};
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) mshr_q[i] <= mshr_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_wr_en   <= 1'b0;
      cache_wr_idx  <= '0;
      cache_wr_tag  <= '0;
      cache_wr_data <= '0;
    end else begin
      cache_wr_en <= cmpl_vld;
      if (cmpl_vld) begin
        cache_wr_idx  <= cmpl_line[SET_BITS-1:0];
        cache_wr_tag  <= cmpl_line[28:SET_BITS];
        cache_wr_data <= mem.Imem2proc_data;
      end
    end
  end

endmodule
